exe_alu_pipe: RTL and testbench
===============================

EXE_ALU_PIPE -- requirements
Module: exe_alu_pipe

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width in bits, legal range 8..64.
REQ-002 Parameter LATENCY, default 2: cycles from accepted start to valid, legal range 1..8.
REQ-003 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  request; it SHALL be accepted only in a cycle where busy=0.
REQ-006 op  input  3  operation select, sampled at accept.
REQ-007 a, b  input  WIDTH each  operands, sampled at accept.
REQ-008 busy  output  1  SHALL be high while an accepted operation has not yet reached its valid cycle.
REQ-009 valid  output  1  SHALL be a one-cycle pulse marking a new result.
REQ-010 result  output  WIDTH  registered result, held between valid pulses.
REQ-011 ovf  output  1  signed overflow flag, qualified by valid.
REQ-012 err  output  1  illegal-op flag, qualified by valid.

Function
REQ-013 Op encoding SHALL be:
  - 000 add; 001 sub (a-b); 010 and; 011 or; 100 xor.
  - 101 slt, signed: result = {0..,1} if a<b, else 0.
  - 110 sltu, unsigned compare, same result format.
  - 111 illegal.
REQ-014 Arithmetic SHALL wrap modulo 2^WIDTH; ovf SHALL be signed overflow for add/sub and 0 for all other ops.
REQ-015 Op 111 SHALL produce result=0, ovf=0, err=1; err SHALL be 0 for every legal op.
REQ-016 The FSM SHALL have two states, IDLE and BUSY, plus a down-counter of width $clog2(LATENCY+1).
REQ-017 Accept: start=1 and busy=0 in cycle T SHALL register op/a/b and load the counter with LATENCY-1.
REQ-018 Transitions:
  - IDLE->BUSY on accept when LATENCY>1.
  - BUSY->IDLE when the counter reaches 0.
  - The counter SHALL decrement each cycle while in BUSY.
REQ-019 valid SHALL be 1 in cycle T+LATENCY only; result/ovf/err SHALL update at that same edge.
REQ-020 busy SHALL be 1 in cycles T+1..T+LATENCY-1 and 0 in cycle T+LATENCY; for LATENCY=1, busy SHALL stay 0.
REQ-021 start while busy=1 SHALL be ignored: no state change and no later valid.
REQ-022 start in the valid cycle SHALL be accepted, giving back-to-back results every LATENCY cycles.
REQ-023 Operand inputs SHALL be don't-care outside accept cycles; results SHALL depend only on the captured values.
REQ-024 result, ovf and err SHALL hold their last values until the next valid.

Reset
REQ-025 With rst_n=0 at a clock edge, the block SHALL set state=IDLE, counter=0, busy=0, valid=0, result=0, ovf=0, err=0.
REQ-026 Reset during BUSY SHALL abandon the operation; no valid SHALL follow.
REQ-027 start sampled in a reset cycle SHALL be ignored.

Structure
REQ-028 Package exe_pkg SHALL hold:
  - the op enum typedef (OP_ADD..OP_ILL);
  - the FSM state typedef;
  - the default WIDTH and LATENCY constants.
REQ-029 Sub-module exe_alu_core (combinational: op, a, b -> result, ovf, err) SHALL hold all arithmetic.
REQ-030 exe_alu_pipe SHALL hold the capture registers, FSM, counter and output registers.

Verification
REQ-031 WIDTH=32, LATENCY=2: start, op=000, a=5, b=7 at T -> valid only at T+2, result=12, ovf=0, busy=1 at T+1 only.
REQ-032 op=001, a=0x80000000, b=1 -> result=0x7FFFFFFF, ovf=1; op=000, a=b=0xFFFFFFFF -> result=0xFFFFFFFE, ovf=0.
REQ-033 op=101 vs op=110 with a=0xFFFFFFFF, b=1 -> slt result=1, sltu result=0; op=111 -> result=0, err=1.
REQ-034 start held high for 6 cycles with LATENCY=2 -> exactly 3 valid pulses at T+2, T+4, T+6; starts at T+1, T+3, T+5 ignored.
REQ-035 rst_n=0 at T+1 after start at T -> no valid at T+2, all outputs 0; the next start after reset behaves normally.
REQ-036 LATENCY=1 and LATENCY=8 builds: valid at T+1 and T+8 respectively; busy never asserts for LATENCY=1.

Source files
------------

// File: rtl/exe_pkg.sv
// Shared types and defaults for the execute-stage ALU pipe.
// Holds the op encoding, the two-state sequencer encoding and default sizes.
// No logic; imported by exe_alu_core and exe_alu_pipe.
package exe_pkg;

   localparam int DEF_WIDTH   = 32;
   localparam int DEF_LATENCY = 2;

   typedef enum logic [2:0] {
      OP_ADD  = 3'b000,
      OP_SUB  = 3'b001,
      OP_AND  = 3'b010,
      OP_OR   = 3'b011,
      OP_XOR  = 3'b100,
      OP_SLT  = 3'b101,
      OP_SLTU = 3'b110,
      OP_ILL  = 3'b111
   } op_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_e;

endpackage

// File: rtl/exe_alu_core.sv
// Combinational ALU: op, a, b -> result, signed-overflow flag, illegal-op flag.
// Ports: op[2:0], a/b[WIDTH-1:0] in; result[WIDTH-1:0], ovf, err out.
// Zero latency, no flow control; the pipe wrapper decides when to sample it.
module exe_alu_core
   import exe_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result,
   output logic             ovf,
   output logic             err
);

   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] diff;
   logic             lt_s;
   logic             lt_u;

   assign sum  = a + b;
   assign diff = a - b;
   assign lt_s = $signed(a) < $signed(b);
   assign lt_u = a < b;

   always_comb begin
      result = '0;
      ovf    = 1'b0;
      err    = 1'b0;
      case (op_e'(op))
         OP_ADD: begin
            result = sum;
            // Same-sign operands whose sum flips sign.
            ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            result = diff;
            // Opposite-sign operands whose difference takes b's sign.
            ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
         end
         OP_AND:  result = a & b;
         OP_OR:   result = a | b;
         OP_XOR:  result = a ^ b;
         OP_SLT:  result = {{(WIDTH-1){1'b0}}, lt_s};
         OP_SLTU: result = {{(WIDTH-1){1'b0}}, lt_u};
         OP_ILL:  err    = 1'b1;
         default: err    = 1'b1;
      endcase
   end

endmodule

// File: rtl/exe_alu_pipe.sv
// Multi-cycle ALU wrapper: captures op/a/b on start, presents result after LATENCY cycles.
// Ports: clk, rst_n (sync, active-low), start, op, a, b in; busy, valid, result, ovf, err out.
// start is ignored while busy; a start in the valid cycle is accepted (one op per LATENCY).
module exe_alu_pipe
   import exe_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int LATENCY = DEF_LATENCY
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             valid,
   output logic [WIDTH-1:0] result,
   output logic             ovf,
   output logic             err
);

   localparam int            CW       = $clog2(LATENCY + 1);
   localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);
   // With a single-cycle latency the result is registered at the accept edge,
   // so the ALU has to look at the live inputs rather than the capture regs.
   localparam bit            DIRECT   = (LATENCY == 1);

   state_e           state;
   logic [CW-1:0]    cnt;
   logic [2:0]       op_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;

   logic             accept;
   logic [2:0]       alu_op;
   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [WIDTH-1:0] alu_result;
   logic             alu_ovf;
   logic             alu_err;

   assign busy   = (state == ST_BUSY);
   assign accept = start && !busy;

   assign alu_op = DIRECT ? op : op_q;
   assign alu_a  = DIRECT ? a  : a_q;
   assign alu_b  = DIRECT ? b  : b_q;

   exe_alu_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .op     (alu_op),
      .a      (alu_a),
      .b      (alu_b),
      .result (alu_result),
      .ovf    (alu_ovf),
      .err    (alu_err)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         op_q   <= '0;
         a_q    <= '0;
         b_q    <= '0;
         valid  <= 1'b0;
         result <= '0;
         ovf    <= 1'b0;
         err    <= 1'b0;
      end else begin
         valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  op_q <= op;
                  a_q  <= a;
                  b_q  <= b;
                  cnt  <= CNT_LOAD;
                  if (LATENCY > 1) begin
                     state <= ST_BUSY;
                  end else begin
                     valid  <= 1'b1;
                     result <= alu_result;
                     ovf    <= alu_ovf;
                     err    <= alu_err;
                  end
               end
            end
            ST_BUSY: begin
               cnt <= cnt - CW'(1);
               // This edge takes the counter to 0: leave BUSY and publish,
               // so the valid cycle is already IDLE and can accept again.
               if (cnt == CW'(1)) begin
                  state  <= ST_IDLE;
                  valid  <= 1'b1;
                  result <= alu_result;
                  ovf    <= alu_ovf;
                  err    <= alu_err;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_exe_alu_pipe.sv
// Bench for exe_alu_pipe: three instances (LATENCY 2, 1, 8) share operands and reset.
// Driver pushes expected responses into per-instance queues; monitor checks at negedge.
// Reference model works from cycle numbers and plain arithmetic.
module tb_exe_alu_pipe;

   typedef struct {
      int          acc;
      int          due;
      logic [31:0] res;
      logic        ovf;
      logic        err;
   } exp_t;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic [2:0]  start = 3'b000;
   logic [2:0]  op    = 3'b000;
   logic [31:0] a     = 32'd0;
   logic [31:0] b     = 32'd0;

   logic [2:0]  busy_w;
   logic [2:0]  valid_w;
   logic [2:0]  ovf_w;
   logic [2:0]  err_w;
   logic [31:0] res_w [3];

   exp_t        sb [3][$];
   int          free_at [3];
   int          cyc    = 0;
   int          checks = 0;
   int          fails  = 0;
   logic        prev_rst = 1'b0;
   logic [31:0] held_res [3];
   logic        held_ovf [3];
   logic        held_err [3];

   always #5 clk = ~clk;

   exe_alu_pipe #(.WIDTH(32), .LATENCY(2)) u_l2 (
      .clk(clk), .rst_n(rst_n), .start(start[0]), .op(op), .a(a), .b(b),
      .busy(busy_w[0]), .valid(valid_w[0]), .result(res_w[0]), .ovf(ovf_w[0]), .err(err_w[0]));
   exe_alu_pipe #(.WIDTH(32), .LATENCY(1)) u_l1 (
      .clk(clk), .rst_n(rst_n), .start(start[1]), .op(op), .a(a), .b(b),
      .busy(busy_w[1]), .valid(valid_w[1]), .result(res_w[1]), .ovf(ovf_w[1]), .err(err_w[1]));
   exe_alu_pipe #(.WIDTH(32), .LATENCY(8)) u_l8 (
      .clk(clk), .rst_n(rst_n), .start(start[2]), .op(op), .a(a), .b(b),
      .busy(busy_w[2]), .valid(valid_w[2]), .result(res_w[2]), .ovf(ovf_w[2]), .err(err_w[2]));

   function automatic int lat_of(input int i);
      case (i)
         0:       return 2;
         1:       return 1;
         default: return 8;
      endcase
   endfunction

   // Reference ALU from the arithmetic definitions (64-bit signed math for overflow).
   function automatic void ref_alu(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                   output logic [31:0] r, output logic v, output logic e);
      longint sx, sy, s, hi, lo;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      hi = 64'sd2147483647;
      lo = -hi - 64'sd1;
      r = 32'd0; v = 1'b0; e = 1'b0;
      case (o)
         3'd0: begin s = sx + sy; r = x + y; v = (s > hi) || (s < lo); end
         3'd1: begin s = sx - sy; r = x - y; v = (s > hi) || (s < lo); end
         3'd2: r = x & y;
         3'd3: r = x | y;
         3'd4: r = x ^ y;
         3'd5: r = (sx < sy) ? 32'd1 : 32'd0;
         3'd6: r = (x < y) ? 32'd1 : 32'd0;
         default: e = 1'b1;
      endcase
   endfunction

   task automatic chk(input string name, input int inst, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s L=%0d cyc=%0d actual=%0h required=%0h", name, lat_of(inst), cyc, act, req);
      end
   endtask

   // One cycle of stimulus: inputs change 1 time unit after posedge and are
   // sampled at the edge ending this cycle.
   task automatic step(input logic rst, input logic [2:0] st, input logic [2:0] o,
                       input logic [31:0] x, input logic [31:0] y);
      exp_t        e;
      logic [31:0] r;
      logic        v, er;
      @(posedge clk);
      cyc++;
      #1;
      rst_n = rst; start = st; op = o; a = x; b = y;
      ref_alu(o, x, y, r, v, er);
      for (int i = 0; i < 3; i++) begin
         if (!rst) begin
            free_at[i] = 0;
         end else if (st[i] && cyc >= free_at[i]) begin
            e.acc = cyc; e.due = cyc + lat_of(i);
            e.res = r; e.ovf = v; e.err = er;
            sb[i].push_back(e);
            free_at[i] = e.due;
         end
      end
   endtask

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 5))
         0:       return 32'h8000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h7FFF_FFFF;
         3:       return 32'($urandom_range(0, 3));
         default: return $urandom;
      endcase
   endfunction

   // Monitor
   initial begin
      int   k;
      logic exp_valid;
      logic exp_busy;
      exp_t h;
      for (int i = 0; i < 3; i++) begin
         held_res[i] = 32'd0; held_ovf[i] = 1'b0; held_err[i] = 1'b0;
      end
      @(posedge clk);
      forever begin
         @(negedge clk);
         k = cyc;
         for (int i = 0; i < 3; i++) begin
            if (!prev_rst) begin
               held_res[i] = 32'd0; held_ovf[i] = 1'b0; held_err[i] = 1'b0;
               // An operation in flight across the reset edge is abandoned.
               if (sb[i].size() > 0 && sb[i][0].acc < k && sb[i][0].due >= k)
                  void'(sb[i].pop_front());
            end
            exp_busy  = (sb[i].size() > 0) && (sb[i][0].acc < k) && (k < sb[i][0].due);
            exp_valid = (sb[i].size() > 0) && (sb[i][0].due == k);
            chk("busy", i, 64'(busy_w[i]), 64'(exp_busy));
            chk("valid", i, 64'(valid_w[i]), 64'(exp_valid));
            if (exp_valid) begin
               h = sb[i].pop_front();
               if (valid_w[i]) begin
                  held_res[i] = h.res; held_ovf[i] = h.ovf; held_err[i] = h.err;
               end
            end
            chk("result", i, 64'(res_w[i]), 64'(held_res[i]));
            chk("ovf", i, 64'(ovf_w[i]), 64'(held_ovf[i]));
            chk("err", i, 64'(err_w[i]), 64'(held_err[i]));
         end
         prev_rst = rst_n;
      end
   end

   // Driver
   initial begin
      logic [2:0]  d_op [9];
      logic [31:0] d_a  [9];
      logic [31:0] d_b  [9];
      logic        r;
      d_op[0] = 3'd0; d_a[0] = 32'd5;         d_b[0] = 32'd7;
      d_op[1] = 3'd1; d_a[1] = 32'h8000_0000; d_b[1] = 32'd1;
      d_op[2] = 3'd0; d_a[2] = 32'hFFFF_FFFF; d_b[2] = 32'hFFFF_FFFF;
      d_op[3] = 3'd5; d_a[3] = 32'hFFFF_FFFF; d_b[3] = 32'd1;
      d_op[4] = 3'd6; d_a[4] = 32'hFFFF_FFFF; d_b[4] = 32'd1;
      d_op[5] = 3'd7; d_a[5] = 32'd3;         d_b[5] = 32'd4;
      d_op[6] = 3'd2; d_a[6] = 32'hF0F0_1234; d_b[6] = 32'h0FF0_FFFF;
      d_op[7] = 3'd3; d_a[7] = 32'hA000_0001; d_b[7] = 32'h0500_0010;
      d_op[8] = 3'd0; d_a[8] = 32'h7FFF_FFFF; d_b[8] = 32'd1;
      for (int i = 0; i < 3; i++) free_at[i] = 0;

      step(1'b0, 3'b000, 3'd0, 32'd0, 32'd0);
      step(1'b0, 3'b111, 3'd0, 32'd1, 32'd1);

      // Directed vectors, each followed by idle cycles with junk operands.
      for (int v = 0; v < 9; v++) begin
         step(1'b1, 3'b111, d_op[v], d_a[v], d_b[v]);
         for (int j = 0; j < 9; j++)
            step(1'b1, 3'b000, 3'($urandom_range(0, 7)), $urandom, $urandom);
      end

      // start held for 6 cycles on the LATENCY=2 instance.
      for (int j = 0; j < 6; j++)
         step(1'b1, 3'b001, 3'($urandom_range(0, 6)), pick_operand(), pick_operand());
      for (int j = 0; j < 9; j++) step(1'b1, 3'b000, 3'd0, 32'd0, 32'd0);

      // Reset one cycle after start, start during reset, then a normal op.
      step(1'b1, 3'b111, 3'd0, 32'd5, 32'd7);
      step(1'b0, 3'b111, 3'd1, 32'd9, 32'd2);
      step(1'b1, 3'b000, 3'd0, 32'd0, 32'd0);
      step(1'b1, 3'b111, 3'd0, 32'd1, 32'd2);
      for (int j = 0; j < 9; j++) step(1'b1, 3'b000, 3'd0, 32'd0, 32'd0);

      // Random traffic with occasional resets.
      for (int j = 0; j < 3000; j++) begin
         r = ($urandom_range(0, 63) != 0);
         step(r, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), pick_operand(), pick_operand());
      end

      for (int j = 0; j < 12; j++) step(1'b1, 3'b000, 3'd0, 32'd0, 32'd0);
      @(negedge clk);
      #1;
      for (int i = 0; i < 3; i++) chk("drain", i, 64'(sb[i].size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
